// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - two-requester arbiter in front of a shared pipelined multiplier
// Optional feature: define MULT_ARB_RR_EN for round-robin arbitration (default is fixed priority, requester 0 wins).
module mult_arbiter #(
    parameter int WIDTH   = 12,
    parameter int MUL_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic                 req1_valid,
    output logic                 req0_ready,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic                 rsp0_valid,
    output logic                 rsp1_valid,
    output logic [2*WIDTH-1:0]   rsp0_c,
    output logic [2*WIDTH-1:0]   rsp1_c,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_c,
    output logic                 busy
);

    logic                 grant0;
    logic                 grant1;
    logic                 accept;

    logic [WIDTH-1:0]     mul_a_q;
    logic [WIDTH-1:0]     mul_b_q;

    // Stage 0 tracks the operand register, stages 1..MUL_LAT track the multiplier
    // stages, so the top stage is valid exactly while mul_c holds its product.
    logic [MUL_LAT:0]     vld_q;
    logic [MUL_LAT:0]     vld_d;
    logic [MUL_LAT:0]     tag_q;
    logic [MUL_LAT:0]     tag_d;

    logic                 rsp0_valid_q;
    logic                 rsp1_valid_q;
    logic [2*WIDTH-1:0]   rsp0_c_q;
    logic [2*WIDTH-1:0]   rsp1_c_q;
    logic                 rsp0_due;
    logic                 rsp1_due;

`ifdef MULT_ARB_RR_EN
    // Requester favoured on a tie: the one not granted at the most recent accept.
    logic                 prio_q;

    // Round-robin grant; a lone valid always wins, ties go to the pointer.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (req0_valid && req1_valid) begin
                grant0 = !prio_q;
                grant1 = prio_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    // Pointer moves only when a transfer is actually accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else if (grant0) begin
            prio_q <= 1'b1;
        end else if (grant1) begin
            prio_q <= 1'b0;
        end
    end
`else
    // Fixed-priority grant; requester 0 always wins a tie.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            grant0 = req0_valid;
            grant1 = req1_valid && !req0_valid;
        end
    end
`endif

    // A grant is only ever given to an asserted valid, so a grant is an accept.
    assign accept     = grant0 | grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Operand register feeding the shared multiplier; holds when nothing is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a_q <= '0;
            mul_b_q <= '0;
        end else if (grant0) begin
            mul_a_q <= req0_a;
            mul_b_q <= req0_b;
        end else if (grant1) begin
            mul_a_q <= req1_a;
            mul_b_q <= req1_b;
        end
    end

    assign vld_d = {vld_q[MUL_LAT-1:0], accept};
    assign tag_d = {tag_q[MUL_LAT-1:0], grant1};

    // Valid/tag shift pipeline marching alongside the multiplier stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            tag_q <= '0;
        end else begin
            vld_q <= vld_d;
            tag_q <= tag_d;
        end
    end

    assign rsp0_due = vld_q[MUL_LAT] && !tag_q[MUL_LAT];
    assign rsp1_due = vld_q[MUL_LAT] &&  tag_q[MUL_LAT];

    // Response stage: capture the product for the tagged requester and strobe once.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_c_q     <= '0;
            rsp1_c_q     <= '0;
        end else begin
            rsp0_valid_q <= rsp0_due;
            rsp1_valid_q <= rsp1_due;
            if (rsp0_due) begin
                rsp0_c_q <= mul_c;
            end
            if (rsp1_due) begin
                rsp1_c_q <= mul_c;
            end
        end
    end

    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_c     = rsp0_c_q;
    assign rsp1_c     = rsp1_c_q;
    assign busy       = (|vld_q) | rsp0_valid_q | rsp1_valid_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - directed self-checking bench for mult_arbiter
`timescale 1ns/1ps
module tb_mult_arbiter;

    localparam int W = 12;
`ifdef MULT_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           req0_valid, req1_valid;
    logic           req0_ready, req1_ready;
    logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic           rsp0_valid, rsp1_valid;
    logic [2*W-1:0] rsp0_c, rsp1_c;
    logic [W-1:0]   mul_a, mul_b;
    logic [2*W-1:0] mul_c;
    logic           busy;

    int n_assert = 0;
    int n_fail   = 0;
    int cnt0, cnt1;
    logic [W-1:0] hold_a, hold_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [2*W-1:0] m1, m2;
    always @(posedge clk) begin
        m1 <= {12'b0, mul_a} * {12'b0, mul_b};
        m2 <= m1;
    end
    assign mul_c = m2;

    always #5 clk = ~clk;

    mult_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp0_valid (rsp0_valid),
        .rsp1_valid (rsp1_valid),
        .rsp0_c     (rsp0_c),
        .rsp1_c     (rsp1_c),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_c      (mul_c),
        .busy       (busy)
    );

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        @(negedge clk);
        @(negedge clk);
        req0_valid = 1'b1;
        #1;
        chk("rst_ready0", req0_ready, 1'b0);
        chk("rst_ready1", req1_ready, 1'b0);
        chk("rst_rsp0_valid", rsp0_valid, 1'b0);
        chk("rst_rsp1_valid", rsp1_valid, 1'b0);
        chk("rst_rsp0_c", rsp0_c, 24'h0);
        chk("rst_rsp1_c", rsp1_c, 24'h0);
        chk("rst_mul_a", mul_a, 12'h0);
        chk("rst_mul_b", mul_b, 12'h0);
        chk("rst_busy", busy, 1'b0);

        rst = 1'b0;
        req0_a = 12'h124; req0_b = 12'h321;
        #1;
        chk("single_ready0", req0_ready, 1'b1);
        chk("single_ready1", req1_ready, 1'b0);
        @(negedge clk);
        req0_valid = 1'b0;
        chk("single_mul_a", mul_a, 12'h124);
        chk("single_mul_b", mul_b, 12'h321);
        chk("single_busy", busy, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("single_early_rsp0", rsp0_valid, 1'b0);
        end
        @(negedge clk);
        chk("single_rsp0_valid", rsp0_valid, 1'b1);
        chk("single_rsp0_c", rsp0_c, 24'h0391A4);
        chk("single_rsp1_valid", rsp1_valid, 1'b0);
        @(negedge clk);
        chk("single_rsp0_pulse", rsp0_valid, 1'b0);
        chk("single_rsp0_hold", rsp0_c, 24'h0391A4);

        hold_a = mul_a; hold_b = mul_b;
        for (int i = 0; i < 10; i++) begin
            chk("idle_busy", busy, 1'b0);
            chk("idle_mul_a", mul_a, hold_a);
            chk("idle_mul_b", mul_b, hold_b);
            chk("idle_rsp0", rsp0_valid, 1'b0);
            @(negedge clk);
        end

        req1_valid = 1'b1; req1_a = 12'hFFF; req1_b = 12'hFFF;
        #1;
        chk("b2b_ready1_first", req1_ready, 1'b1);
        @(negedge clk);
        req1_a = 12'h008; req1_b = 12'h002;
        #1;
        chk("b2b_ready1_second", req1_ready, 1'b1);
        @(negedge clk);
        req1_valid = 1'b0;
        chk("b2b_mul_a", mul_a, 12'h008);
        @(negedge clk);
        chk("b2b_early_rsp1", rsp1_valid, 1'b0);
        @(negedge clk);
        chk("b2b_rsp1_valid_0", rsp1_valid, 1'b1);
        chk("b2b_rsp1_c_0", rsp1_c, 24'hFFE001);
        @(negedge clk);
        chk("b2b_rsp1_valid_1", rsp1_valid, 1'b1);
        chk("b2b_rsp1_c_1", rsp1_c, 24'h000010);
        chk("b2b_rsp0_quiet", rsp0_valid, 1'b0);
        chk("b2b_rsp0_hold", rsp0_c, 24'h0391A4);
        @(negedge clk);
        chk("b2b_rsp1_done", rsp1_valid, 1'b0);
        chk("b2b_busy_done", busy, 1'b0);

        req0_valid = 1'b1; req0_a = 12'd2; req0_b = 12'd3;
        req1_valid = 1'b1; req1_a = 12'd5; req1_b = 12'd7;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("tie_ready0", req0_ready, RR ? (i % 2 == 0) : 1'b1);
            chk("tie_ready1", req1_ready, RR ? (i % 2 == 1) : 1'b0);
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp0_valid) begin
                cnt0++;
                chk("tie_rsp0_c", rsp0_c, 24'd6);
            end
            if (rsp1_valid) begin
                cnt1++;
                chk("tie_rsp1_c", rsp1_c, 24'd35);
            end
            @(negedge clk);
        end
        chk("tie_rsp0_count", cnt0, RR ? 2 : 4);
        chk("tie_rsp1_count", cnt1, RR ? 2 : 0);
        chk("tie_busy_done", busy, 1'b0);

        req0_valid = 1'b1; req0_a = 12'h0AB; req0_b = 12'h0CD;
        @(negedge clk);
        req0_valid = 1'b0;
        rst = 1'b1;
        chk("mid_busy_before", busy, 1'b1);
        @(negedge clk);
        chk("mid_busy", busy, 1'b0);
        chk("mid_mul_a", mul_a, 12'h0);
        chk("mid_mul_b", mul_b, 12'h0);
        chk("mid_rsp0_c", rsp0_c, 24'h0);
        chk("mid_rsp1_c", rsp1_c, 24'h0);
        chk("mid_rsp0_valid", rsp0_valid, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mid_no_rsp0", rsp0_valid, 1'b0);
            chk("mid_no_rsp1", rsp1_valid, 1'b0);
            chk("mid_idle_busy", busy, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
